monobit_bit_feeder: RTL

//  Upstream stage of the monobit frequency test. Accepts byte-wide entropy samples over a valid/ready handshake,

---
 rtl/monobit_bit_feeder_pkg.sv | 26 ++
 rtl/monobit_byte_fifo.sv | 55 +++++
 rtl/monobit_bit_feeder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/monobit_bit_feeder_pkg.sv
// Shared cadence constants, feeder state encoding and control bundle
// for the monobit frequency test front end.
package monobit_bit_feeder_pkg;

  localparam int MONOBIT_BEAT_CYCLES = 3;
  localparam int MONOBIT_WINDOW_BITS = 128;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_RUN    = 2'd1,
    FEED_RESYNC = 2'd2
  } feed_state_t;

  typedef struct packed {
    logic take;
    logic underrun;
    logic load;
  } feed_ctl_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/monobit_byte_fifo.sv
// Small sample FIFO between the entropy source and the serialiser.
// Registered read side only: a pushed entry is visible next cycle.
module monobit_byte_fifo
  import monobit_bit_feeder_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_dat,
  output logic              full,
  output logic              empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/monobit_bit_feeder.sv
// Serialises buffered entropy bytes into the monobit core's epsilon bit
// and owns the core reset so every window starts cleanly.
module monobit_bit_feeder
  import monobit_bit_feeder_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int BEAT_CYCLES = MONOBIT_BEAT_CYCLES,
  parameter int WINDOW_BITS = MONOBIT_WINDOW_BITS,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic              bit_dat,
  output logic              core_rst,
  output logic              win_done,
  output logic [7:0]        underrun_cnt
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int IW = (WINDOW_BITS > 1) ? $clog2(WINDOW_BITS) : 1;

  localparam logic [CW-1:0] SH_FULL   = CW'(DATA_W);
  localparam logic [CW-1:0] SH_ONE    = CW'(1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WINDOW_BITS - 1);

  feed_state_t       state;
  feed_state_t       state_nxt;
  feed_ctl_t         ctl;
  logic [DATA_W-1:0] sh_reg;
  logic [DATA_W-1:0] sh_next;
  logic [DATA_W-1:0] fifo_dat;
  logic [CW-1:0]     sh_cnt;
  logic [BW-1:0]     beat_cnt;
  logic [IW-1:0]     bit_idx;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              beat0;

  assign in_rdy = !fifo_full;
  assign push   = in_vld && in_rdy;

  monobit_byte_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (in_dat),
    .pop      (ctl.load),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign beat0 = (state == FEED_RUN) && (beat_cnt == '0);

  always_comb begin
    ctl          = '0;
    ctl.take     = beat0 && (sh_cnt != '0);
    ctl.underrun = beat0 && (sh_cnt == '0);
    ctl.load     = !fifo_empty &&
                   ((sh_cnt == '0) ||
                    (ctl.take && (sh_cnt == SH_ONE)));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FEED_IDLE: begin
        if (sh_cnt == SH_FULL) begin
          state_nxt = FEED_RUN;
        end
      end
      FEED_RUN: begin
        if (ctl.underrun) begin
          state_nxt = FEED_RESYNC;
        end
      end
      FEED_RESYNC: begin
        state_nxt = FEED_IDLE;
      end
      default: begin
        state_nxt = FEED_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FEED_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Beat counter sits at 0 outside RUN so the core's first
  // FSM beat lines up with the first take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (state != FEED_RUN) begin
      beat_cnt <= '0;
    end else if (beat_cnt == BEAT_LAST) begin
      beat_cnt <= '0;
    end else begin
      beat_cnt <= beat_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
    end else if (state != FEED_RUN) begin
      bit_idx <= '0;
    end else if (ctl.take) begin
      bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_done     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      win_done <= ctl.take && (bit_idx == IDX_LAST);
      if (ctl.underrun) begin
        underrun_cnt <= sat_inc8(underrun_cnt);
      end
    end
  end

  assign sh_next = MSB_FIRST ? {sh_reg[DATA_W-2:0], 1'b0}
                             : {1'b0, sh_reg[DATA_W-1:1]};

  // Shifting in zeros keeps bit_dat at 0 once the byte is spent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_reg <= '0;
      sh_cnt <= '0;
    end else if (ctl.load) begin
      sh_reg <= fifo_dat;
      sh_cnt <= SH_FULL;
    end else if (ctl.take) begin
      sh_reg <= sh_next;
      sh_cnt <= sh_cnt - SH_ONE;
    end
  end

  assign bit_dat  = MSB_FIRST ? sh_reg[DATA_W-1] : sh_reg[0];
  assign core_rst = (state != FEED_RUN);

endmodule
